// File: rtl/add_sub_pipe_if.sv
// Operand/result handshake bundle for add_sub_pipe.
// master drives operands and out_ready; slave is the pipeline itself.
interface add_sub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/add_sub_pipe.sv
// Pipelined WIDTH-bit two's-complement adder/subtractor: one WIDTH/STAGES slice
// per stage, carry registered between stages, valid/ready with full backpressure.
module add_sub_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    add_sub_pipe_if.slave bus
);
    localparam int WS = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("add_sub_pipe: STAGES must divide WIDTH and lie in 1..WIDTH");
    end

    logic             stall;
    logic             accept;
    logic             cin_eff;
    logic [WIDTH-1:0] b_eff;

    // A full stall freezes every stage; empty slots are never squeezed out.
    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;
    assign accept       = bus.in_valid && !stall;
    assign b_eff        = bus.sub ? ~bus.b : bus.b;
    assign cin_eff      = bus.cin ^ bus.sub;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        // REM: operand bits still to be added on entry; DONE: sum bits complete on exit.
        localparam int REM  = WIDTH - gi * WS;
        localparam int DONE = (gi + 1) * WS;

        logic [REM-1:0]  op_a;
        logic [REM-1:0]  op_b;
        logic            c_in;
        logic            v_in;
        logic [WS:0]     slice;
        logic [DONE-1:0] sum_next;
        logic [DONE-1:0] sum_reg;
        logic            carry_reg;
        logic            valid_reg;

        if (gi == 0) begin : g_head
            assign op_a     = bus.a;
            assign op_b     = b_eff;
            assign c_in     = cin_eff;
            assign v_in     = accept;
            assign sum_next = slice[WS-1:0];
        end else begin : g_tail
            assign op_a     = g_stage[gi-1].g_upper.op_a_reg;
            assign op_b     = g_stage[gi-1].g_upper.op_b_reg;
            assign c_in     = g_stage[gi-1].carry_reg;
            assign v_in     = g_stage[gi-1].valid_reg;
            assign sum_next = {slice[WS-1:0], g_stage[gi-1].sum_reg};
        end

        assign slice = {1'b0, op_a[WS-1:0]} + {1'b0, op_b[WS-1:0]} + {{WS{1'b0}}, c_in};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                carry_reg <= 1'b0;
                sum_reg   <= '0;
            end else if (!stall) begin
                valid_reg <= v_in;
                carry_reg <= slice[WS];
                sum_reg   <= sum_next;
            end
        end

        if (gi < STAGES - 1) begin : g_upper
            // Operand slices not yet added ride along with the beat.
            logic [REM-WS-1:0] op_a_reg;
            logic [REM-WS-1:0] op_b_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    op_a_reg <= '0;
                    op_b_reg <= '0;
                end else if (!stall) begin
                    op_a_reg <= op_a[REM-1:WS];
                    op_b_reg <= op_b[REM-1:WS];
                end
            end
        end else begin : g_last
            // Signed overflow: like-signed operands yielding an opposite-signed result.
            logic ovf_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_reg <= 1'b0;
                end else if (!stall) begin
                    ovf_reg <= (op_a[WS-1] == op_b[WS-1]) && (slice[WS-1] != op_a[WS-1]);
                end
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].valid_reg;
    assign bus.sum       = g_stage[STAGES-1].sum_reg;
    assign bus.cout      = g_stage[STAGES-1].carry_reg;
    assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_reg;
endmodule

// File: tb/tb_add_sub_pipe.sv
// Drives four add_sub_pipe configurations with shared stimulus and checks each
// against an arithmetic reference model and an in-order scoreboard.
module tb_add_sub_pipe;
    localparam int NCFG = 4;

    function automatic int cfg_w(int i);
        case (i)
            0:       return 16;
            1:       return 16;
            2:       return 32;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_s(int i);
        case (i)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a_drv = '0;
    logic [31:0] b_drv = '0;

    logic [NCFG-1:0]       in_ready_v;
    logic [NCFG-1:0]       out_valid_v;
    logic [NCFG-1:0]       cout_v;
    logic [NCFG-1:0]       ovf_v;
    logic [NCFG-1:0][31:0] sum_v;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
        localparam int W = cfg_w(gi);
        localparam int S = cfg_s(gi);

        add_sub_pipe_if #(.WIDTH(W)) bus ();

        assign bus.in_valid  = in_valid;
        assign bus.a         = a_drv[W-1:0];
        assign bus.b         = b_drv[W-1:0];
        assign bus.cin       = cin;
        assign bus.sub       = sub;
        assign bus.out_ready = out_ready;

        assign in_ready_v[gi]  = bus.in_ready;
        assign out_valid_v[gi] = bus.out_valid;
        assign cout_v[gi]      = bus.cout;
        assign ovf_v[gi]       = bus.ovf;
        assign sum_v[gi]       = 32'(bus.sum);

        add_sub_pipe #(.WIDTH(W), .STAGES(S)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic lat_chk = 1'b0;
    logic dir_rec = 1'b0;
    logic [NCFG-1:0] prev_stall = '0;

    logic [33:0] exp_q[NCFG][$];
    int          acc_q[NCFG][$];
    logic [33:0] dir_q[$];

    logic [31:0] dir_a   [5] = '{32'h0000FFFF, 32'h00007FFF, 32'h00000005, 32'h00008000, 32'h00008000};
    logic [31:0] dir_b   [5] = '{32'h00000001, 32'h00000001, 32'h00000007, 32'h00000001, 32'h00000001};
    logic        dir_cin [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        dir_sub [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    // {ovf, cout, sum} for the 16-bit, 4-stage instance.
    logic [33:0] dir_exp [5] = '{{2'b01, 32'h00000000}, {2'b10, 32'h00008000},
                                 {2'b00, 32'h0000FFFE}, {2'b11, 32'h00007FFF},
                                 {2'b11, 32'h00007FFE}};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Returns {ovf, cout, sum} from signed/unsigned integer arithmetic.
    function automatic logic [33:0] model(int w, logic [31:0] a, logic [31:0] b, logic c, logic s);
        longint mask = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua   = longint'(a) & mask;
        longint ub   = longint'(b) & mask;
        longint ci   = c ? 64'sd1 : 64'sd0;
        longint sa   = (ua >= half) ? ua - (mask + 1) : ua;
        longint sb   = (ub >= half) ? ub - (mask + 1) : ub;
        longint res;
        longint sr;
        logic   co;
        logic   ov;
        if (s) begin
            res = ua - ub - ci;
            co  = (ua >= ub + ci);
            sr  = sa - sb - ci;
        end else begin
            res = ua + ub + ci;
            co  = (res > mask);
            sr  = sa + sb + ci;
        end
        ov = (sr >= half) || (sr < -half);
        return {ov, co, 32'(res & mask)};
    endfunction

    task automatic monitor();
        for (int i = 0; i < NCFG; i++) begin
            logic [33:0] got;
            logic        stall;
            got   = {ovf_v[i], cout_v[i], sum_v[i]};
            stall = out_valid_v[i] && !out_ready;
            check($sformatf("in_ready[%0d]", i), 64'(in_ready_v[i]), 64'(!stall));
            if (prev_stall[i])
                check($sformatf("hold_valid[%0d]", i), 64'(out_valid_v[i]), 64'd1);
            if (out_valid_v[i]) begin
                if (exp_q[i].size() == 0) begin
                    check($sformatf("stale_beat[%0d]", i), 64'(out_valid_v[i]), 64'd0);
                end else begin
                    check($sformatf("result[%0d]", i), 64'(got), 64'(exp_q[i][0]));
                    if (out_ready) begin
                        if (lat_chk)
                            check($sformatf("latency[%0d]", i), 64'(cyc - acc_q[i][0]), 64'(cfg_s(i)));
                        if (i == 0 && dir_rec)
                            dir_q.push_back(got);
                        void'(exp_q[i].pop_front());
                        void'(acc_q[i].pop_front());
                    end
                end
            end
            if (in_valid && in_ready_v[i]) begin
                exp_q[i].push_back(model(cfg_w(i), a_drv, b_drv, cin, sub));
                acc_q[i].push_back(cyc);
            end
            prev_stall[i] = stall;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_ops();
        a_drv = $urandom;
        b_drv = $urandom;
        cin   = 1'($urandom_range(0, 1));
        sub   = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset();
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("rst_out_valid[%0d]", i), 64'(out_valid_v[i]), 64'd0);
            check($sformatf("rst_sum[%0d]", i), 64'(sum_v[i]), 64'd0);
            check($sformatf("rst_cout[%0d]", i), 64'(cout_v[i]), 64'd0);
            check($sformatf("rst_ovf[%0d]", i), 64'(ovf_v[i]), 64'd0);
            check($sformatf("rst_in_ready[%0d]", i), 64'(in_ready_v[i]), 64'd1);
        end
    endtask

    task automatic drain_check(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) tick();
        for (int i = 0; i < NCFG; i++)
            check($sformatf("%s_left[%0d]", tag, i), 64'(exp_q[i].size()), 64'd0);
    endtask

    initial begin
        #2;
        check_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Corner vectors, no backpressure.
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        dir_rec   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            a_drv    = dir_a[k];
            b_drv    = dir_b[k];
            cin      = dir_cin[k];
            sub      = dir_sub[k];
            tick();
        end
        drain_check("dir");
        dir_rec = 1'b0;
        check("dir_count", 64'(dir_q.size()), 64'd5);
        for (int k = 0; k < 5 && k < dir_q.size(); k++)
            check($sformatf("dir_vec%0d", k), 64'(dir_q[k]), 64'(dir_exp[k]));

        // Full throughput random stream.
        for (int k = 0; k < 40; k++) begin
            in_valid = 1'b1;
            rand_ops();
            tick();
        end
        drain_check("stream");

        // Random backpressure; operands change every cycle whether accepted or not.
        lat_chk = 1'b0;
        for (int k = 0; k < 200; k++) begin
            in_valid  = ($urandom_range(0, 9) != 0);
            out_ready = 1'($urandom_range(0, 1));
            rand_ops();
            tick();
        end
        drain_check("bp");

        // Asynchronous reset with beats in flight.
        lat_chk = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            rand_ops();
            tick();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset();
        for (int i = 0; i < NCFG; i++) begin
            exp_q[i].delete();
            acc_q[i].delete();
        end
        prev_stall = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        repeat (12) tick();
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            rand_ops();
            tick();
        end
        drain_check("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/add_sub_pipe.md
# add_sub_pipe

Parametrised, pipelined two's-complement adder/subtractor and the successor to the team's fixed 4-bit ripple full adder. WIDTH-bit operands are split into STAGES equal slices; each pipeline stage adds one slice and registers its carry into the next stage, so the critical path is one slice rather than the full word. Operands enter and results leave through valid/ready handshakes with full backpressure. It sits in the datapath wherever wide add/subtract must close timing at core clock.

## Interface
- WIDTH, 16, operand and result width in bits; WIDTH % STAGES == 0 required (elaboration error otherwise)
- STAGES, 4, pipeline depth and slice count; 1 <= STAGES <= WIDTH; slice width W_S = WIDTH/STAGES
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset; deassertion synchronised externally
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0: add, 1: subtract
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out; in subtract mode 1 = no borrow
- ovf  out  1  signed overflow

## Operation
- Add (sub=0): {cout,sum} = a + b + cin.
- Subtract (sub=1): sum = a - b - cin, computed as a + ~b + ~cin; cout is the raw carry of that addition (1 = no borrow).
- ovf = carry into MSB XOR carry out of MSB (equivalently: operand signs of a and effective b equal, sum sign differs).
- Operand inversion and carry-in conversion happen combinationally at the input, before stage 0 registers.
- Stage k (0..STAGES-1) adds slice k (bits k*W_S +: W_S) of a and effective b plus the carry registered by stage k-1 (stage 0 uses converted cin).
- Skew: upper, not-yet-added operand slices travel with the beat through stages; completed lower sum slices are delayed so all slices of a beat emerge together.
- Each stage holds a valid bit; the last stage's valid bit drives out_valid; sum/cout/ovf come straight from last-stage registers (no output combinational logic).
- Handshake: beat accepted when in_valid && in_ready; result consumed when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall. On stall every stage register (data and valid) holds. No bubble compression: in_ready stays low during stall even if internal stages are empty.
- Not stalled: every stage advances one position; stage 0 loads the input beat if accepted, else loads valid=0.
- Operands, sub and cin are sampled only on acceptance; changes while in_ready=0 have no effect.
- Results leave in acceptance order; no beat dropped or duplicated.

## Timing
- Reset (rst_n low, asynchronous): all valid bits 0, all data/carry registers 0; hence out_valid=0, sum=0, cout=0, ovf=0, in_ready=1 (no stall possible).
- Reset mid-operation discards all in-flight beats immediately; first acceptance possible on the first rising edge after rst_n deasserts.
- Latency: beat accepted at edge n appears with out_valid=1 after edge n+STAGES-1 (i.e. STAGES register stages; STAGES=1 gives result one cycle after acceptance), plus any stall cycles.
- Throughput: one beat per cycle when out_ready held high.
- Simultaneous: while out_valid && out_ready, a new beat is accepted the same cycle (in_ready=1); pipeline stays full.
- out_valid, sum, cout, ovf stable while out_valid && !out_ready.
- in_ready is combinational from out_ready and out_valid only; no path from in_valid to in_ready.

## Test plan
- WIDTH=16, STAGES=4, out_ready=1: a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1; a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
- a=0x8000, b=0x0001, cin=0, sub=1 -> sum=0x7FFF, cout=1, ovf=1; same with cin=1 -> sum=0x7FFE, cout=1, ovf=1.
- Stream 64 random beats back-to-back with out_ready random 50%: outputs match reference model in order, outputs stable during stall, in_ready == !(out_valid && !out_ready) every cycle.
- Accept 3 beats, assert rst_n=0 asynchronously mid-cycle -> out_valid, sum, cout, ovf go 0 without a clock edge; after release no stale beat emerges.
- Repeat random and corner runs for (WIDTH,STAGES) = (16,1), (32,8), (8,8): latency equals STAGES, results identical to model.
